// File: rtl/folded_csa_accumulator.sv
// Folds an operand stream through one 3:2 compressor into redundant S/C, resolves once at the end.
// One operand/cycle; result valid one edge after the last accept; input stalls while a result is pending.
module folded_csa_accumulator #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [CNT_W-1:0] out_count,
    output logic             out_capped
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_c;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out_result;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_capped;
    logic             r_out_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_maj;
    logic [WIDTH-1:0] w_carry;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_at_cap;

    assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign w_accept   = in_valid && in_ready;
    assign w_sum      = r_s ^ r_c ^ in_data;
    assign w_maj      = (r_s & r_c) | (r_s & in_data) | (r_c & in_data);
    // Carry out of the top bit is dropped: arithmetic is modulo 2^WIDTH.
    assign w_carry    = {w_maj[WIDTH-2:0], 1'b0};
    assign w_cnt_next = r_count + CNT_W'(1);
    assign w_at_cap   = (w_cnt_next == CNT_W'(MAX_OPS));

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_count  = r_out_count;
    assign out_capped = r_out_capped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_c          <= '0;
            r_count      <= '0;
            r_out_result <= '0;
            r_out_count  <= '0;
            r_out_capped <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_s          <= in_data;
                        r_c          <= '0;
                        r_count      <= CNT_W'(1);
                        r_out_capped <= (MAX_OPS == 1) && !in_last;
                        r_state      <= (in_last || MAX_OPS == 1) ? ST_RESOLVE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s     <= w_sum;
                        r_c     <= w_carry;
                        r_count <= w_cnt_next;
                        if (in_last || w_at_cap) begin
                            r_state <= ST_RESOLVE;
                        end
                        if (!in_last && w_at_cap) begin
                            r_out_capped <= 1'b1;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_out_result <= r_s + r_c;
                    r_out_count  <= r_count;
                    r_out_valid  <= 1'b1;
                    r_state      <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_folded_csa_accumulator.sv
// Directed bench for folded_csa_accumulator: latency, gaps, wrap, backpressure, cap and reset.
module tb_folded_csa_accumulator;

    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = $clog2(MAX_OPS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [CNT_W-1:0] out_count;
    logic             out_capped;

    int errors = 0;
    int checks = 0;

    folded_csa_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_capped (out_capped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] r,
                               input int cnt, input logic cap);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_res"}, {32'd0, out_result}, {32'd0, r});
        chk({tag, "_cnt"}, {59'd0, out_count}, 64'(cnt));
        chk({tag, "_cap"}, {63'd0, out_capped}, {63'd0, cap});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_rdy_set"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_count", {59'd0, out_count}, 64'd0);
        chk("rst_out_capped", {63'd0, out_capped}, 64'd0);

        // 1: single operand, exact latency
        send(32'h0000_0005, 1'b1);
        chk("t1_resolve_vld", {63'd0, out_valid}, 64'd0);
        chk("t1_resolve_rdy", {63'd0, in_ready}, 64'd0);
        tick();
        chk("t1_vld_T1", {63'd0, out_valid}, 64'd1);
        chk("t1_rdy_done", {63'd0, in_ready}, 64'd0);
        wait_result("t1", 32'h0000_0005, 1, 1'b0);
        handshake("t1");

        // 2: operands with two-cycle gaps
        send(32'd1, 1'b0);
        tick(); tick();
        chk("t2_gap_rdy", {63'd0, in_ready}, 64'd1);
        chk("t2_gap_vld", {63'd0, out_valid}, 64'd0);
        send(32'd2, 1'b0);
        tick(); tick();
        send(32'd3, 1'b1);
        wait_result("t2", 32'h0000_0006, 3, 1'b0);
        handshake("t2");

        // 3: modulo wrap
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0001, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0001, 1'b1);
        wait_result("t3", 32'h0000_0001, 4, 1'b0);
        handshake("t3");

        // 4: output backpressure
        send(32'h1234_5678, 1'b1);
        wait_result("t4", 32'h1234_5678, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_vld", {63'd0, out_valid}, 64'd1);
            chk("t4_hold_res", {32'd0, out_result}, 64'h1234_5678);
            chk("t4_hold_rdy", {63'd0, in_ready}, 64'd0);
        end
        handshake("t4");

        // 5: cap at MAX_OPS with no in_last
        for (int i = 0; i < MAX_OPS; i++) send(32'h1000_0001, 1'b0);
        chk("t5_rdy_after_cap", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
        wait_result("t5", 32'h0000_0010, 16, 1'b1);
        tick();
        chk("t5_17th_blocked", {63'd0, in_ready}, 64'd0);
        handshake("t5");
        in_valid = 1'b0; in_last = 1'b0;
        chk("t5_res_held", {32'd0, out_result}, 64'h0000_0010);

        // 6: reset mid-stream
        send(32'hAAAA_AAAA, 1'b0);
        send(32'h5555_5555, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_rdy", {63'd0, in_ready}, 64'd1);
        chk("t6_rst_vld", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_cnt", {59'd0, out_count}, 64'd0);
        send(32'h0000_0007, 1'b1);
        wait_result("t6", 32'h0000_0007, 1, 1'b0);
        handshake("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
